// File: rtl/vmchin_pkg.sv
// Shared constants and types for the coin payer and the vending-machine side.
// Latency: n/a (package only).
// Backpressure: n/a.
package vmchin_pkg;

    // Purchase price in rupees; 3 bits holds any paid amount (max 4).
    localparam logic [2:0] PRICE     = 3'd3;
    localparam logic [2:0] COIN1_VAL = 3'd1;
    localparam logic [2:0] COIN2_VAL = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COIN = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Total rupee value of a wallet (max 15 + 30 = 45).
    function automatic logic [5:0] wallet_value(input logic [3:0] n1,
                                                input logic [3:0] n2);
        return {2'b00, n1} + {1'b0, n2, 1'b0};
    endfunction

endpackage

// File: rtl/vmchin_payer_if.sv
// Handshake bundle between the payer and the vending machine / wallet loader.
// Latency: n/a (wires only).
// Backpressure: none; all strobes are single-cycle pulses.
// Ports: load/n1_load/n2_load/start/pr/re toward the payer (slave inputs);
//        rs1/rs2/busy/done/fail/w1/w2/chg_cnt from the payer (slave outputs).
interface vmchin_payer_if;
    logic       load;
    logic [3:0] n1_load;
    logic [3:0] n2_load;
    logic       start;
    logic       pr;
    logic       re;
    logic       rs1;
    logic       rs2;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] w1;
    logic [3:0] w2;
    logic [7:0] chg_cnt;

    modport slave (
        input  load, n1_load, n2_load, start, pr, re,
        output rs1, rs2, busy, done, fail, w1, w2, chg_cnt
    );

    modport master (
        output load, n1_load, n2_load, start, pr, re,
        input  rs1, rs2, busy, done, fail, w1, w2, chg_cnt
    );
endinterface

// File: rtl/vmchin_payer.sv
// Pays a fixed price from a 1/2-rupee wallet, one coin every 2 cycles, then waits for release.
// Latency: coin pulse 1 cycle after COIN entry; done/fail pulse 1 cycle after the deciding sample.
// Backpressure: none; start/load outside IDLE are dropped, no purchase is queued.
// Ports: clk, rst (async active-high), bus (vmchin_payer_if.slave).
// Optional: VMPAY_CHANGE_CHECK_EN makes a wrong change return at release a failure.
module vmchin_payer
    import vmchin_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           rst,
    vmchin_payer_if.slave  bus
);

    localparam int             TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    paid_q,  paid_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic          rs1_q,   rs1_d;
    logic          rs2_q,   rs2_d;
    logic          done_q,  done_d;
    logic          fail_q,  fail_d;
    logic [3:0]    w1_q,    w1_d;
    logic [3:0]    w2_q,    w2_d;
    logic [7:0]    chg_q,   chg_d;

    logic [2:0]    remain;
    logic          pick2;
    logic          change_ok;

    always_comb begin
        state_d = state_q;
        paid_d  = paid_q;
        tmo_d   = tmo_q;
        rs1_d   = 1'b0;
        rs2_d   = 1'b0;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        w1_d    = w1_q;
        w2_d    = w2_q;
        chg_d   = chg_q;

        // Only meaningful in COIN, where paid never exceeds PRICE.
        remain = PRICE - paid_q;
        // Prefer a 2-rupee coin while 2+ is still owed; also use one for the
        // last rupee when no 1-rupee coin is left (overpays by one).
        pick2  = ((remain >= 3'd2) && (w2_q != 4'd0)) ||
                 ((remain == 3'd1) && (w1_q == 4'd0));

`ifdef VMPAY_CHANGE_CHECK_EN
        // Change is owed exactly when one rupee was overpaid.
        change_ok = (bus.re == (paid_q == (PRICE + 3'd1)));
`else
        change_ok = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    w1_d = bus.n1_load;
                    w2_d = bus.n2_load;
                end else if (bus.start) begin
                    if (wallet_value(w1_q, w2_q) < {3'b000, PRICE}) begin
                        fail_d = 1'b1;
                    end else begin
                        paid_d  = 3'd0;
                        tmo_d   = '0;
                        state_d = ST_COIN;
                    end
                end
            end
            ST_COIN: begin
                if (pick2) begin
                    rs2_d  = 1'b1;
                    w2_d   = w2_q - 4'd1;
                    paid_d = paid_q + COIN2_VAL;
                end else begin
                    rs1_d  = 1'b1;
                    w1_d   = w1_q - 4'd1;
                    paid_d = paid_q + COIN1_VAL;
                end
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.pr) begin
                    // Change is banked even when the purchase is judged failed.
                    if (bus.re) begin
                        if (w1_q != 4'hF) begin
                            w1_d = w1_q + 4'd1;
                        end
                        chg_d = chg_q + 8'd1;
                    end
                    if ((paid_q >= PRICE) && change_ok) begin
                        done_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (bus.re) begin
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (paid_q < PRICE) begin
                    state_d = ST_COIN;
                end else if (tmo_q == TMO_LAST) begin
                    fail_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            paid_q  <= 3'd0;
            tmo_q   <= '0;
            rs1_q   <= 1'b0;
            rs2_q   <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            w1_q    <= 4'd0;
            w2_q    <= 4'd0;
            chg_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            paid_q  <= paid_d;
            tmo_q   <= tmo_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.rs1     = rs1_q;
    assign bus.rs2     = rs2_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.fail    = fail_q;
    assign bus.w1      = w1_q;
    assign bus.w2      = w2_q;
    assign bus.chg_cnt = chg_q;

endmodule

// File: tb/tb_vmchin_payer.sv
// Bench for vmchin_payer: directed purchases plus randomized purchases against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vmchin_payer;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vmchin_payer_if bus();

    vmchin_payer #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Purchase seen as: a run of coins, each followed by one listening cycle,
    // then up to TIMEOUT listening cycles once the price is covered.
    int   m_w1, m_w2, m_chg, m_paid, m_listen;
    bit   m_active, m_coin_next;
    logic e_rs1, e_rs2, e_done, e_fail, e_busy;

    always @(posedge clk or posedge rst) begin
        int  rem;
        bit  ok;
        if (rst) begin
            m_w1 = 0; m_w2 = 0; m_chg = 0; m_paid = 0; m_listen = 0;
            m_active = 0; m_coin_next = 0;
            e_rs1 = 0; e_rs2 = 0; e_done = 0; e_fail = 0; e_busy = 0;
        end else begin
            e_rs1 = 0; e_rs2 = 0; e_done = 0; e_fail = 0;
            if (!m_active) begin
                if (bus.load) begin
                    m_w1 = int'(bus.n1_load);
                    m_w2 = int'(bus.n2_load);
                end else if (bus.start) begin
                    if (m_w1 + 2 * m_w2 < 3) e_fail = 1;
                    else begin
                        m_active = 1; m_paid = 0; m_coin_next = 1;
                    end
                end
            end else if (m_coin_next) begin
                rem = 3 - m_paid;
                if ((rem >= 2 && m_w2 > 0) || (rem == 1 && m_w1 == 0)) begin
                    e_rs2 = 1; m_w2 = m_w2 - 1; m_paid = m_paid + 2;
                end else begin
                    e_rs1 = 1; m_w1 = m_w1 - 1; m_paid = m_paid + 1;
                end
                m_coin_next = 0;
                m_listen = 0;
            end else begin
                if (bus.pr) begin
                    if (bus.re) begin
                        if (m_w1 < 15) m_w1 = m_w1 + 1;
                        m_chg = (m_chg + 1) % 256;
                    end
                    ok = (m_paid >= 3);
`ifdef VMPAY_CHANGE_CHECK_EN
                    if (bus.re != (m_paid == 4)) ok = 0;
`endif
                    if (ok) e_done = 1; else e_fail = 1;
                    m_active = 0;
                end else if (bus.re) begin
                    e_fail = 1; m_active = 0;
                end else if (m_paid < 3) begin
                    m_coin_next = 1;
                end else begin
                    m_listen = m_listen + 1;
                    if (m_listen == TIMEOUT) begin
                        e_fail = 1; m_active = 0;
                    end
                end
            end
            e_busy = m_active;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("rs1",     bus.rs1,  e_rs1);
            check("rs2",     bus.rs2,  e_rs2);
            check("done",    bus.done, e_done);
            check("fail",    bus.fail, e_fail);
            check("busy",    bus.busy, e_busy);
            check("w1",      bus.w1,   m_w1[3:0]);
            check("w2",      bus.w2,   m_w2[3:0]);
            check("chg_cnt", bus.chg_cnt, m_chg[7:0]);
            check("rs_excl", bus.rs1 & bus.rs2, 1'b0);
            check("df_excl", bus.done & bus.fail, 1'b0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input int n1, input int n2);
        @(posedge clk); #1;
        bus.load = 1; bus.n1_load = 4'(n1); bus.n2_load = 4'(n2);
        @(posedge clk); #1;
        bus.load = 0;
    endtask

    // spur: 0 normal, 1 early pr, 2 early re. pr_delay >= TIMEOUT lets it time out.
    task automatic run_purchase(input int pr_delay, input bit re_val, input int spur,
                                output int c1, output int c2, output int first,
                                output bit got_done, output bit got_fail,
                                output bit saw_busy, output int lat);
        int paid_seen, since, last_coin, cyc;
        bit fired, finished;
        c1 = 0; c2 = 0; first = 0; got_done = 0; got_fail = 0; saw_busy = 0; lat = -1;
        paid_seen = 0; since = 0; last_coin = 0; cyc = 0; fired = 0; finished = 0;
        @(posedge clk); #1;
        bus.start = 1;
        while (!finished && cyc < 60) begin
            @(posedge clk); #1;
            bus.start = 0; bus.pr = 0; bus.re = 0; bus.load = 0;
            cyc++;
            if (bus.busy) saw_busy = 1;
            if (bus.rs1) begin c1++; paid_seen += 1; last_coin = cyc; if (first == 0) first = 1; end
            if (bus.rs2) begin c2++; paid_seen += 2; last_coin = cyc; if (first == 0) first = 2; end
            if (bus.done) begin got_done = 1; finished = 1; lat = cyc - last_coin; end
            if (bus.fail) begin got_fail = 1; finished = 1; lat = cyc - last_coin; end
            if (!finished) begin
                if (spur == 1 && !fired && (c1 + c2) == 1) begin
                    bus.pr = 1; fired = 1;
                end else if (spur == 2 && !fired && (c1 + c2) == 1) begin
                    bus.re = 1; fired = 1;
                end else if (paid_seen >= 3 && !fired) begin
                    if (since == pr_delay) begin
                        bus.pr = 1; bus.re = re_val; fired = 1;
                    end
                    since++;
                end
                // Strobes the payer must ignore while busy.
                if ($urandom_range(0, 3) == 0) begin
                    bus.load = 1; bus.n1_load = 4'($urandom); bus.n2_load = 4'($urandom);
                end
                if ($urandom_range(0, 3) == 0) bus.start = 1;
            end
        end
        if (!finished) check("purchase_cycle_budget", 32'd0, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  c1, c2, first, lat;
        bit  gd, gf, sb;
        bit  seen;
        bus.load = 0; bus.n1_load = 0; bus.n2_load = 0;
        bus.start = 0; bus.pr = 0; bus.re = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        check("reset_busy",  bus.busy, 1'b0);
        check("reset_w1",    bus.w1,   4'd0);
        check("reset_w2",    bus.w2,   4'd0);
        check("reset_chg",   bus.chg_cnt, 8'd0);

        // Three 1-rupee coins, prompt release, no change.
        do_load(3, 0);
        run_purchase(0, 1'b0, 0, c1, c2, first, gd, gf, sb, lat);
        check("d1_rs1_count", c1, 3);
        check("d1_rs2_count", c2, 0);
        check("d1_done", gd, 1'b1);
        check("d1_w1", bus.w1, 4'd0);
        check("d1_chg", bus.chg_cnt, 8'd0);

        // 2-rupee first, then 1-rupee.
        do_load(1, 1);
        run_purchase(0, 1'b0, 0, c1, c2, first, gd, gf, sb, lat);
        check("d2_first_coin", first, 2);
        check("d2_rs1_count", c1, 1);
        check("d2_rs2_count", c2, 1);
        check("d2_done", gd, 1'b1);
        check("d2_w1", bus.w1, 4'd0);
        check("d2_w2", bus.w2, 4'd0);
        check("d2_chg", bus.chg_cnt, 8'd0);

        // Two 2-rupee coins overpay; one rupee of change returns.
        do_load(0, 2);
        run_purchase(0, 1'b1, 0, c1, c2, first, gd, gf, sb, lat);
        check("d3_rs2_count", c2, 2);
        check("d3_rs1_count", c1, 0);
        check("d3_done", gd, 1'b1);
        check("d3_w1", bus.w1, 4'd1);
        check("d3_w2", bus.w2, 4'd0);
        check("d3_chg", bus.chg_cnt, 8'd1);

        // Insufficient funds.
        do_load(2, 0);
        run_purchase(0, 1'b0, 0, c1, c2, first, gd, gf, sb, lat);
        check("d4_fail", gf, 1'b1);
        check("d4_no_coin", c1 + c2, 0);
        check("d4_busy_low", sb, 1'b0);
        check("d4_fail_latency", lat, 1);

        // Release never comes: timeout.
        do_load(3, 0);
        run_purchase(99, 1'b0, 0, c1, c2, first, gd, gf, sb, lat);
        check("d5_rs1_count", c1, 3);
        check("d5_fail", gf, 1'b1);
        check("d5_fail_latency", lat, 4);
        check("d5_w1", bus.w1, 4'd0);

        // Reset between first and second coin.
        do_load(3, 0);
        @(posedge clk); #1 bus.start = 1;
        @(posedge clk); #1 bus.start = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.rs1) seen = 1;
        end
        check("d6_first_coin_seen", seen, 1'b1);
        #2 rst = 1;
        #1;
        check("d6_async_rs1",  bus.rs1,  1'b0);
        check("d6_async_busy", bus.busy, 1'b0);
        check("d6_async_w1",   bus.w1,   4'd0);
        check("d6_async_chg",  bus.chg_cnt, 8'd0);
        check("d6_async_df",   {bus.done, bus.fail, bus.rs2, bus.w2}, 32'd0);
        @(posedge clk); #3 rst = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.rs1 || bus.rs2 || bus.busy || bus.done || bus.fail) seen = 1;
        end
        check("d6_quiet_after_reset", seen, 1'b0);

        // Randomized purchases; the per-cycle compare does the checking.
        for (int t = 0; t < 150; t++) begin
            int spur;
            if ($urandom_range(0, 2) != 0)
                do_load($urandom_range(0, 6), $urandom_range(0, 3));
            spur = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
            run_purchase($urandom_range(0, 5), 1'($urandom_range(0, 1)), spur,
                         c1, c2, first, gd, gf, sb, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got no end expected end before 1000000ns");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vmchin_payer.md
VMCHIN_PAYER -- requirements
Module: vmchin_payer

Interface
REQ-001 Parameter TIMEOUT, default 4: WAIT cycles allowed after full payment before abort.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  wallet load strobe, honoured only in IDLE.
REQ-005 n1_load  input  4  1-rupee coin count loaded on load.
REQ-006 n2_load  input  4  2-rupee coin count loaded on load.
REQ-007 start  input  1  purchase request, honoured only in IDLE with load low.
REQ-008 pr  input  1  product-release pulse from vending machine.
REQ-009 re  input  1  change-return pulse (one 1-rupee coin) from vending machine.
REQ-010 rs1  output  1  one-cycle 1-rupee coin-insert pulse, registered.
REQ-011 rs2  output  1  one-cycle 2-rupee coin-insert pulse, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse: purchase completed.
REQ-014 fail  output  1  one-cycle pulse: purchase aborted.
REQ-015 w1, w2  output  4 each  current wallet coin counts.
REQ-016 chg_cnt  output  8  total change coins received, wraps 255->0.

Function
REQ-017 States IDLE, COIN, WAIT; PRICE = 3 rupees; paid register 3 bits.
REQ-018 IDLE, start: if w1 + 2*w2 < PRICE, fail pulses next cycle, no coin inserted, stay IDLE; else paid<=0, go COIN.
REQ-019 COIN lasts one cycle: rs2 if (PRICE-paid >= 2 and w2>0) or (PRICE-paid == 1 and w1==0); else rs1; decrement matching wallet count, add coin value to paid; go WAIT.
REQ-020 rs1 and rs2 never high together; neither high outside COIN.
REQ-021 WAIT samples pr/re each cycle: pr with paid >= PRICE -> done pulse next cycle, go IDLE.
REQ-022 WAIT, no pr, paid < PRICE -> go COIN (coin spacing exactly 2 cycles).
REQ-023 WAIT, no pr, paid >= PRICE -> count cycles; TIMEOUT cycles without pr -> fail pulse, go IDLE.
REQ-024 pr while paid < PRICE, or re without pr -> fail pulse, go IDLE, coins not refunded.
REQ-025 re sampled with pr: w1 increments (saturate at 15), chg_cnt increments.
REQ-026 start or load outside IDLE ignored; load has priority over start in IDLE.
REQ-027 done and fail never high together.

Reset
REQ-028 rst forces IDLE, paid=0, timeout counter=0, rs1=rs2=busy=done=fail=0, w1=w2=0, chg_cnt=0 immediately.
REQ-029 rst mid-purchase abandons it with no done/fail pulse after release.

Configuration
REQ-030 VMPAY_CHANGE_CHECK_EN defined: at pr, re must equal (paid - PRICE == 1); mismatch -> fail pulse instead of done, wallet/chg_cnt still updated.
REQ-031 VMPAY_CHANGE_CHECK_EN undefined: re only counted, never causes fail when accompanied by pr.

Structure
REQ-032 Shared package vmchin_pkg holds PRICE, coin values, state encoding, shared with vending-machine code.
REQ-033 Single module, no sub-module; coin selection is inline combinational logic.

Verification
REQ-034 w1=3,w2=0, start, machine model -> rs1 x3 two cycles apart, pr after third, done, re=0, w1=0.
REQ-035 w1=1,w2=1, start -> rs2 then rs1, pr, done, w1=w2=0, chg_cnt=0.
REQ-036 w1=0,w2=2, start -> rs2 x2, pr+re, done, w1=1, w2=0, chg_cnt=1.
REQ-037 w1=2,w2=0, start -> fail next cycle, no rs1/rs2, busy stays 0.
REQ-038 w1=3, pr tied 0 -> three rs1, fail exactly 4 cycles after last WAIT entry, w1=0.
REQ-039 rst asserted between first and second coin -> all outputs 0 asynchronously, no further coin after release.
